grad_mag_pipe: RTL and testbench

- Parametrised successor to the gradient magnitude stage: accepts signed Sobel gx/gy and produces an unsigned magnitude estimate.
- The approximation mode is selectable per beat: L1, max+min/2, alpha-max-beta-min, or L-inf.
- Output is saturated to a configurable width, and a per-beat threshold compare produces an edge flag.
- Sits between the Sobel convolution and the non-max/threshold stage; valid/ready on both sides with a 3-stage pipeline.

---
 rtl/grad_pkg.sv | 22 ++
 rtl/grad_abs_sort.sv | 27 ++
 rtl/grad_mag_pipe.sv | 137 +++++++++++++
 tb/tb_grad_mag_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grad_pkg
// Brief    : Shared types and constants for the gradient magnitude datapath.
// Revision : 1.0
// ============================================================================
package grad_pkg;

  typedef enum logic [1:0] {
    GRAD_L1      = 2'd0,
    GRAD_MAXHALF = 2'd1,
    GRAD_AMBM    = 2'd2,
    GRAD_LINF    = 2'd3
  } grad_mode_e;

  // Alpha-max-beta-min: alpha = 1 - 2^-4, beta = 2^-1 - 2^-5.
  localparam int unsigned c_AMBM_MX_SHIFT      = 4;
  localparam int unsigned c_AMBM_MN_SHIFT      = 1;
  localparam int unsigned c_AMBM_MN_FINE_SHIFT = 5;

endpackage
`default_nettype wire

// File: rtl/grad_abs_sort.sv
`default_nettype none
// ============================================================================
// Module   : grad_abs_sort
// Brief    : Absolute value of two signed gradients, sorted into max/min.
// Revision : 1.0
// ============================================================================
module grad_abs_sort #(
  parameter int WIDTH_P = 8
) (
  input  logic signed [WIDTH_P-1:0] i_gx,
  input  logic signed [WIDTH_P-1:0] i_gy,
  output logic        [WIDTH_P-1:0] o_mx,
  output logic        [WIDTH_P-1:0] o_mn
);

  logic [WIDTH_P-1:0] w_ax;
  logic [WIDTH_P-1:0] w_ay;

  // Negating the most negative code wraps to 2^(WIDTH_P-1), exact as unsigned.
  assign w_ax = i_gx[WIDTH_P-1] ? $unsigned(-i_gx) : $unsigned(i_gx);
  assign w_ay = i_gy[WIDTH_P-1] ? $unsigned(-i_gy) : $unsigned(i_gy);

  assign o_mx = (w_ax >= w_ay) ? w_ax : w_ay;
  assign o_mn = (w_ax >= w_ay) ? w_ay : w_ax;

endmodule
`default_nettype wire

// File: rtl/grad_mag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : grad_mag_pipe
// Brief    : 3-stage gradient magnitude estimator with saturation and edge flag.
// Revision : 1.0
// ============================================================================
module grad_mag_pipe
  import grad_pkg::*;
#(
  parameter int WIDTH_P     = 8,
  parameter int OUT_WIDTH_P = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WIDTH_P-1:0]     gx_i,
  input  logic [WIDTH_P-1:0]     gy_i,
  input  logic [1:0]             mode_i,
  input  logic [OUT_WIDTH_P-1:0] thresh_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [OUT_WIDTH_P-1:0] mag_o,
  output logic                   edge_o,
  output logic                   sat_o
);

  generate
    if (OUT_WIDTH_P < 1 || OUT_WIDTH_P > WIDTH_P + 1) begin : g_bad_out_width
      $error("grad_mag_pipe: OUT_WIDTH_P must lie in 1..WIDTH_P+1");
    end
  endgenerate

  logic                   w_en;
  logic [WIDTH_P-1:0]     w_mx;
  logic [WIDTH_P-1:0]     w_mn;
  logic [WIDTH_P:0]       w_mx_ext;
  logic [WIDTH_P:0]       w_mn_ext;
  logic [WIDTH_P:0]       w_s;
  logic                   w_sat;
  logic [OUT_WIDTH_P-1:0] w_mag;
  logic                   w_edge;

  // Stage 1: sorted magnitudes plus per-beat controls.
  logic                   r_v1;
  logic [WIDTH_P-1:0]     r_mx1;
  logic [WIDTH_P-1:0]     r_mn1;
  grad_mode_e             r_mode1;
  logic [OUT_WIDTH_P-1:0] r_th1;

  // Stage 2: unsaturated magnitude.
  logic                   r_v2;
  logic [WIDTH_P:0]       r_s2;
  logic [OUT_WIDTH_P-1:0] r_th2;

  // Stage 3: output register.
  logic                   r_v3;
  logic [OUT_WIDTH_P-1:0] r_mag3;
  logic                   r_edge3;
  logic                   r_sat3;

  assign w_en    = ready_i | ~r_v3;
  assign ready_o = w_en;

  grad_abs_sort #(
    .WIDTH_P (WIDTH_P)
  ) u_abs_sort (
    .i_gx (gx_i),
    .i_gy (gy_i),
    .o_mx (w_mx),
    .o_mn (w_mn)
  );

  assign w_mx_ext = {1'b0, r_mx1};
  assign w_mn_ext = {1'b0, r_mn1};

  always_comb begin
    w_s = '0;
    case (r_mode1)
      GRAD_L1:      w_s = w_mx_ext + w_mn_ext;
      GRAD_MAXHALF: w_s = w_mx_ext + (w_mn_ext >> 1);
      GRAD_AMBM:    w_s = w_mx_ext - (w_mx_ext >> c_AMBM_MX_SHIFT)
                          + (w_mn_ext >> c_AMBM_MN_SHIFT)
                          - (w_mn_ext >> c_AMBM_MN_FINE_SHIFT);
      default:      w_s = w_mx_ext;
    endcase
  end

  // At OUT_WIDTH_P = WIDTH_P+1 the largest sum (2^WIDTH_P) always fits.
  generate
    if (OUT_WIDTH_P <= WIDTH_P) begin : g_sat_cmp
      assign w_sat = |r_s2[WIDTH_P:OUT_WIDTH_P];
    end else begin : g_sat_none
      assign w_sat = 1'b0;
    end
  endgenerate

  assign w_mag  = w_sat ? {OUT_WIDTH_P{1'b1}} : r_s2[OUT_WIDTH_P-1:0];
  assign w_edge = (w_mag >= r_th2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1    <= 1'b0;
      r_mx1   <= '0;
      r_mn1   <= '0;
      r_mode1 <= GRAD_L1;
      r_th1   <= '0;
      r_v2    <= 1'b0;
      r_s2    <= '0;
      r_th2   <= '0;
      r_v3    <= 1'b0;
      r_mag3  <= '0;
      r_edge3 <= 1'b0;
      r_sat3  <= 1'b0;
    end else if (w_en) begin
      r_v1    <= valid_i;
      r_mx1   <= w_mx;
      r_mn1   <= w_mn;
      r_mode1 <= grad_mode_e'(mode_i);
      r_th1   <= thresh_i;
      r_v2    <= r_v1;
      r_s2    <= w_s;
      r_th2   <= r_th1;
      r_v3    <= r_v2;
      r_mag3  <= w_mag;
      r_edge3 <= w_edge;
      r_sat3  <= w_sat;
    end
  end

  assign valid_o = r_v3;
  assign mag_o   = r_mag3;
  assign edge_o  = r_edge3;
  assign sat_o   = r_sat3;

endmodule
`default_nettype wire

// File: tb/tb_grad_mag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_grad_mag_pipe
// Brief    : Scoreboard bench for grad_mag_pipe at OUT_WIDTH_P = 6, 8 and 9.
// Revision : 1.0
// ============================================================================
module tb_grad_mag_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       ready_i;
  logic [7:0] gx, gy;
  logic [1:0] mode;
  logic [8:0] thresh;

  logic       rdy6, rdy8, rdy9;
  logic       vo6, vo8, vo9;
  logic [5:0] mag6;
  logic [7:0] mag8;
  logic [8:0] mag9;
  logic       edge6, edge8, edge9;
  logic       sat6, sat8, sat9;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_pop  = 0;
  bit chk_lat = 1'b1;

  typedef struct {
    logic [7:0] gx;
    logic [7:0] gy;
    logic [1:0] mode;
    logic [8:0] th;
    int         cyc;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grad_mag_pipe #(.WIDTH_P(8), .OUT_WIDTH_P(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy6),
    .gx_i(gx), .gy_i(gy), .mode_i(mode), .thresh_i(thresh[5:0]),
    .valid_o(vo6), .ready_i(ready_i), .mag_o(mag6), .edge_o(edge6), .sat_o(sat6));

  grad_mag_pipe #(.WIDTH_P(8), .OUT_WIDTH_P(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy8),
    .gx_i(gx), .gy_i(gy), .mode_i(mode), .thresh_i(thresh[7:0]),
    .valid_o(vo8), .ready_i(ready_i), .mag_o(mag8), .edge_o(edge8), .sat_o(sat8));

  grad_mag_pipe #(.WIDTH_P(8), .OUT_WIDTH_P(9)) dut9 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy9),
    .gx_i(gx), .gy_i(gy), .mode_i(mode), .thresh_i(thresh),
    .valid_o(vo9), .ready_i(ready_i), .mag_o(mag9), .edge_o(edge9), .sat_o(sat9));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: internal sum from the mode formulas on non-negative integers.
  function automatic int calc_s(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
    int ax, ay, mx, mn;
    ax = $signed(x);
    ay = $signed(y);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    case (m)
      2'd0:    return mx + mn;
      2'd1:    return mx + mn / 2;
      2'd2:    return mx - mx / 16 + mn / 2 - mn / 32;
      default: return mx;
    endcase
  endfunction

  function automatic int sat_mag(input int s, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (s > lim) ? lim : s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_i && rdy8)
        q.push_back('{gx: gx, gy: gy, mode: mode, th: thresh, cyc: cyc});
      if (vo8 && ready_i) begin
        check("q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          beat_t b;
          int    s, m6, m8, m9;
          b  = q.pop_front();
          n_pop++;
          s  = calc_s(b.gx, b.gy, b.mode);
          m6 = sat_mag(s, 6);
          m8 = sat_mag(s, 8);
          m9 = sat_mag(s, 9);
          check("mag6",  mag6,  m6);
          check("edge6", edge6, 32'(m6 >= int'(b.th[5:0])));
          check("sat6",  sat6,  32'(s > 63));
          check("mag8",  mag8,  m8);
          check("edge8", edge8, 32'(m8 >= int'(b.th[7:0])));
          check("sat8",  sat8,  32'(s > 255));
          check("mag9",  mag9,  m9);
          check("edge9", edge9, 32'(m9 >= int'(b.th)));
          check("sat9",  sat9,  32'(s > 511));
          check("valid6", vo6, 1);
          check("valid9", vo9, 1);
          if (chk_lat) check("latency", cyc - b.cyc, 3);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Presents a beat and holds it until accepted; returns at posedge+1.
  task automatic put(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input logic [8:0] th);
    bit ok;
    ok = 1'b0;
    gx = x; gy = y; mode = m; thresh = th; valid_i = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = rdy8;
    end
    if (!ok) check("put_timeout", 0, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Single beat into an empty pipe: checks the 3-cycle latency and dut8 outputs.
  task automatic send_wait(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m,
                           input logic [8:0] th, input logic [7:0] em, input logic ee, input logic es);
    sync();
    put(x, y, m, th);
    @(negedge clk); check("lat_c1", vo8, 0);
    @(negedge clk); check("lat_c2", vo8, 0);
    @(negedge clk); check("lat_c3", vo8, 1);
    check("d_mag", mag8, em);
    check("d_edge", edge8, ee);
    check("d_sat", sat8, es);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    check(tag, q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pop0, nb, guard;
    logic       acc;
    logic [7:0] cap_mag;
    logic       cap_edge, cap_sat;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    gx = '0; gy = '0; mode = '0; thresh = '0;

    // Reset state
    @(negedge clk);
    check("rst_valid", vo8, 0);
    check("rst_mag", mag8, 0);
    check("rst_edge", edge8, 0);
    check("rst_sat", sat8, 0);
    check("rst_ready", rdy8, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Mode sweep: gx=3, gy=-4, thresh=5
    send_wait(8'd3, 8'hFC, 2'd0, 9'd5, 8'd7, 1'b1, 1'b0);
    send_wait(8'd3, 8'hFC, 2'd1, 9'd5, 8'd5, 1'b1, 1'b0);
    send_wait(8'd3, 8'hFC, 2'd2, 9'd5, 8'd5, 1'b1, 1'b0);
    send_wait(8'd3, 8'hFC, 2'd3, 9'd5, 8'd4, 1'b0, 1'b0);

    // Extremes
    send_wait(8'h80, 8'h80, 2'd0, 9'd200, 8'd255, 1'b1, 1'b1);
    send_wait(8'h80, 8'h80, 2'd1, 9'd200, 8'd192, 1'b0, 1'b0);
    send_wait(8'h80, 8'h80, 2'd2, 9'd200, 8'd180, 1'b0, 1'b0);
    send_wait(8'h80, 8'h80, 2'd3, 9'd200, 8'd128, 1'b0, 1'b0);
    send_wait(8'd0, 8'd0, 2'd2, 9'd0, 8'd0, 1'b1, 1'b0);

    // Threshold boundary
    send_wait(8'd100, 8'd0, 2'd1, 9'd100, 8'd100, 1'b1, 1'b0);
    send_wait(8'd100, 8'd0, 2'd1, 9'd101, 8'd100, 1'b0, 1'b0);

    // Back-to-back beats alternating mode and threshold
    sync();
    for (int i = 0; i < 8; i++)
      put(8'(20 + 7 * i), 8'(-(11 * i)), 2'(i), 9'(i[0] ? 30 : 90));
    drain("b2b_drain");

    // Backpressure: 5 beats in, stall 4 cycles, then 5 more
    sync();
    pop0 = n_pop;
    for (int i = 0; i < 5; i++) put(8'(i * 13 - 40), 8'(i * 29), 2'(i), 9'(i * 17));
    chk_lat = 1'b0;
    ready_i = 1'b0;
    gx = 8'd77; gy = 8'd33; mode = 2'd2; thresh = 9'd50; valid_i = 1'b1;
    cap_mag = mag8; cap_edge = edge8; cap_sat = sat8;
    repeat (4) begin
      @(negedge clk);
      check("bp_ready", rdy8, 0);
      check("bp_valid", vo8, 1);
      check("bp_mag_hold", mag8, cap_mag);
      check("bp_edge_hold", edge8, cap_edge);
      check("bp_sat_hold", sat8, cap_sat);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    put(8'd77, 8'd33, 2'd2, 9'd50);
    for (int i = 0; i < 4; i++) put(8'(i * 50 - 90), 8'(5 - i), 2'(i + 1), 9'(i * 40));
    drain("bp_drain");
    check("bp_count", n_pop - pop0, 10);
    chk_lat = 1'b1;

    // Asynchronous reset with beats in flight
    sync();
    for (int i = 0; i < 3; i++) put(8'(60 + i), 8'(10 + i), 2'd0, 9'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", vo8, 0);
    check("arst_mag", mag8, 0);
    check("arst_edge", edge8, 0);
    check("arst_sat", sat8, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_stale", vo8, 0);
    end
    send_wait(8'd9, 8'd12, 2'd3, 9'd12, 8'd12, 1'b1, 1'b0);

    // Random regression with random valid/ready
    chk_lat = 1'b0;
    sync();
    pop0 = n_pop;
    nb = 0;
    guard = 0;
    while (nb < 10000 && guard < 60000) begin
      @(negedge clk);
      acc = valid_i && rdy8;
      @(posedge clk); #1;
      guard++;
      if (acc) nb++;
      ready_i = ($urandom_range(0, 3) != 0);
      if (!valid_i || acc) begin
        valid_i = ($urandom_range(0, 2) != 0);
        gx      = 8'($urandom);
        gy      = 8'($urandom);
        mode    = 2'($urandom);
        thresh  = 9'($urandom);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("rand_beats", nb, 10000);
    drain("rand_drain");
    check("rand_count", n_pop - pop0, nb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
